// File: rtl/sc_frame_pkg.sv
// sc_frame_pkg: shared constants for the SKIROC2 slow-control loader.
// Frame layout, field positions and the loader FSM encoding.
package sc_frame_pkg;

    localparam int CHIP_BITS = 616;
    localparam int DAC_POS   = 560;
    localparam int MASK_POS  = 16;
    localparam int DONE_CYC  = 2;

    localparam logic [CHIP_BITS-1:0] BASE_FRAME = {77{8'hA5}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_RSTB,
        ST_SHIFT,
        ST_LOAD,
        ST_DONE
    } sc_state_t;

endpackage

// File: rtl/sc_frame_mux.sv
// sc_frame_mux: picks the serial bit for (chip, bit) with the
// chip's DAC and mask fields overlaid on the base frame.
module sc_frame_mux
    import sc_frame_pkg::*;
(
    input  logic [1:0]   i_chip,
    input  logic [9:0]   i_bit,
    input  logic [47:0]  i_dac,
    input  logic [255:0] i_mask,
    output logic         o_bit
);

    logic [9:0]           w_dac;
    logic [63:0]          w_mask;
    logic [CHIP_BITS-1:0] w_frame;
    logic [9:0]           w_idx;
    logic                 w_unused_dac;

    // Upper two bits of each 12-bit DAC slot are not used by the chip
    assign w_unused_dac = ^{i_dac[47:46], i_dac[35:34],
                            i_dac[23:22], i_dac[11:10]};

    // Select this chip's fields; chip1 occupies the MSB slots
    always_comb begin
        w_dac  = i_dac[36 +: 10];
        w_mask = i_mask[192 +: 64];
        unique case (i_chip)
            2'd0: begin
                w_dac  = i_dac[36 +: 10];
                w_mask = i_mask[192 +: 64];
            end
            2'd1: begin
                w_dac  = i_dac[24 +: 10];
                w_mask = i_mask[128 +: 64];
            end
            2'd2: begin
                w_dac  = i_dac[12 +: 10];
                w_mask = i_mask[64 +: 64];
            end
            2'd3: begin
                w_dac  = i_dac[0 +: 10];
                w_mask = i_mask[0 +: 64];
            end
        endcase
    end

    // Overlay the fields and pick the bit, MSB of the frame first
    always_comb begin
        w_frame                  = BASE_FRAME;
        w_frame[DAC_POS +: 10]   = w_dac;
        w_frame[MASK_POS +: 64]  = w_mask;
        w_idx                    = 10'(CHIP_BITS - 1) - i_bit;
        o_bit                    = w_frame[w_idx];
    end

endmodule

// File: rtl/sc_frame_loader.sv
// sc_frame_loader: shifts the four-chip slow-control chain on a
// rising In_Set_SC and answers with a two-cycle finish pulse.
module sc_frame_loader #(
    parameter int CHIP_BITS = sc_frame_pkg::CHIP_BITS,
    parameter int RSTB_CYC  = 4,
    parameter int LOAD_CYC  = 2
) (
    input  logic         Clk_10MHz,
    input  logic         Rst_N,
    input  logic         In_Set_SC,
    input  logic [47:0]  In_DAC_Code,
    input  logic [255:0] In_Mask_Code,
    output logic         Out_Sr_Ck,
    output logic         Out_Sr_In,
    output logic         Out_Sr_Rstb,
    output logic         Out_Load_SC,
    output logic         Out_Finish_Sc,
    output logic         Out_Busy
);

    import sc_frame_pkg::*;

    localparam int CNT_W = 8;
    localparam logic [9:0] LAST_BIT = 10'(CHIP_BITS - 1);

    sc_state_t      r_state;
    sc_state_t      w_state_nxt;
    logic           r_prev;
    logic           w_start;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic           r_phase;
    logic           w_phase_nxt;
    logic [9:0]     r_bit_cnt;
    logic [9:0]     w_bit_nxt;
    logic [1:0]     r_chip_cnt;
    logic [1:0]     w_chip_nxt;
    logic [47:0]    r_dac;
    logic [255:0]   r_mask;
    logic           w_mux_bit;

    logic r_sr_ck, r_sr_in, r_rstb, r_load, r_fin, r_busy;
    logic w_ck_nxt, w_sdi_nxt, w_rstb_nxt;
    logic w_load_nxt, w_fin_nxt, w_busy_nxt;

    assign w_start = In_Set_SC & ~r_prev;

    // State, counters, edge-detect flop and shadow capture
    always_ff @(posedge Clk_10MHz or negedge Rst_N) begin
        if (!Rst_N) begin
            r_state    <= ST_IDLE;
            r_prev     <= 1'b0;
            r_cnt      <= '0;
            r_phase    <= 1'b0;
            r_bit_cnt  <= '0;
            r_chip_cnt <= '0;
            r_dac      <= '0;
            r_mask     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_prev     <= In_Set_SC;
            r_cnt      <= w_cnt_nxt;
            r_phase    <= w_phase_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_chip_cnt <= w_chip_nxt;
            if (r_state == ST_LATCH) begin
                r_dac  <= In_DAC_Code;
                r_mask <= In_Mask_Code;
            end
        end
    end

    // Sequencing: timed states share one cycle counter
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_phase_nxt = r_phase;
        w_bit_nxt   = r_bit_cnt;
        w_chip_nxt  = r_chip_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start)
                    w_state_nxt = ST_LATCH;
            end
            ST_LATCH: begin
                w_state_nxt = ST_RSTB;
                w_cnt_nxt   = '0;
            end
            ST_RSTB: begin
                if (r_cnt == CNT_W'(RSTB_CYC - 1)) begin
                    w_state_nxt = ST_SHIFT;
                    w_phase_nxt = 1'b0;
                    w_bit_nxt   = '0;
                    w_chip_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_SHIFT: begin
                w_phase_nxt = ~r_phase;
                if (r_phase) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_bit_nxt  = '0;
                        w_chip_nxt = r_chip_cnt + 2'd1;
                        if (r_chip_cnt == 2'd3) begin
                            w_state_nxt = ST_LOAD;
                            w_cnt_nxt   = '0;
                        end
                    end else begin
                        w_bit_nxt = r_bit_cnt + 10'd1;
                    end
                end
            end
            ST_LOAD: begin
                if (r_cnt == CNT_W'(LOAD_CYC - 1)) begin
                    w_state_nxt = ST_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                if (r_cnt == CNT_W'(DONE_CYC - 1))
                    w_state_nxt = ST_IDLE;
                else
                    w_cnt_nxt = r_cnt + 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    sc_frame_mux u_mux (
        .i_chip (w_chip_nxt),
        .i_bit  (w_bit_nxt),
        .i_dac  (r_dac),
        .i_mask (r_mask),
        .o_bit  (w_mux_bit)
    );

    // Outputs decoded from the next state so they register in step
    always_comb begin
        w_ck_nxt   = 1'b0;
        w_sdi_nxt  = 1'b0;
        w_rstb_nxt = 1'b1;
        w_load_nxt = 1'b0;
        w_fin_nxt  = 1'b0;
        w_busy_nxt = 1'b1;
        unique case (w_state_nxt)
            ST_IDLE:  w_busy_nxt = 1'b0;
            ST_RSTB:  w_rstb_nxt = 1'b0;
            ST_SHIFT: begin
                w_ck_nxt  = w_phase_nxt;
                w_sdi_nxt = w_phase_nxt ? r_sr_in : w_mux_bit;
            end
            ST_LOAD:  w_load_nxt = 1'b1;
            ST_DONE:  w_fin_nxt  = 1'b1;
            default:  w_busy_nxt = 1'b1;
        endcase
    end

    // Output registers
    always_ff @(posedge Clk_10MHz or negedge Rst_N) begin
        if (!Rst_N) begin
            r_sr_ck <= 1'b0;
            r_sr_in <= 1'b0;
            r_rstb  <= 1'b1;
            r_load  <= 1'b0;
            r_fin   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_sr_ck <= w_ck_nxt;
            r_sr_in <= w_sdi_nxt;
            r_rstb  <= w_rstb_nxt;
            r_load  <= w_load_nxt;
            r_fin   <= w_fin_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign Out_Sr_Ck     = r_sr_ck;
    assign Out_Sr_In     = r_sr_in;
    assign Out_Sr_Rstb   = r_rstb;
    assign Out_Load_SC   = r_load;
    assign Out_Finish_Sc = r_fin;
    assign Out_Busy      = r_busy;

endmodule

// File: tb/tb_sc_frame_loader.sv
// tb_sc_frame_loader: schedule table, reference stream model and
// hand-written corner sequences for sc_frame_loader.
module tb_sc_frame_loader;

    import sc_frame_pkg::*;

    localparam int FRAME_TOTAL = 4 * CHIP_BITS;

    logic         Clk_10MHz = 1'b0;
    logic         Rst_N = 1'b0;
    logic         In_Set_SC = 1'b0;
    logic [47:0]  In_DAC_Code = '0;
    logic [255:0] In_Mask_Code = '0;
    logic         Out_Sr_Ck, Out_Sr_In, Out_Sr_Rstb;
    logic         Out_Load_SC, Out_Finish_Sc, Out_Busy;

    always #50 Clk_10MHz = ~Clk_10MHz;

    sc_frame_loader dut (
        .Clk_10MHz     (Clk_10MHz),
        .Rst_N         (Rst_N),
        .In_Set_SC     (In_Set_SC),
        .In_DAC_Code   (In_DAC_Code),
        .In_Mask_Code  (In_Mask_Code),
        .Out_Sr_Ck     (Out_Sr_Ck),
        .Out_Sr_In     (Out_Sr_In),
        .Out_Sr_Rstb   (Out_Sr_Rstb),
        .Out_Load_SC   (Out_Load_SC),
        .Out_Finish_Sc (Out_Finish_Sc),
        .Out_Busy      (Out_Busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;

    // monitor state
    logic cap[$];
    logic exp_q[$];
    int   fin_cnt = 0;
    int   m_bad = 0;
    logic m_prev_ck = 1'b0;
    logic m_prev_sdi = 1'b0;
    logic m_prev_fin = 1'b0;

    always @(posedge Clk_10MHz) cyc <= cyc + 1;

    always @(negedge Clk_10MHz) begin
        if (Out_Sr_Ck && !m_prev_ck) begin
            cap.push_back(Out_Sr_In);
            if (Out_Sr_In !== m_prev_sdi) m_bad <= m_bad + 1;
        end
        if (Out_Finish_Sc && !m_prev_fin) fin_cnt <= fin_cnt + 1;
        m_prev_ck  <= Out_Sr_Ck;
        m_prev_sdi <= Out_Sr_In;
        m_prev_fin <= Out_Finish_Sc;
    end

    typedef struct {
        int         c;
        logic [4:0] v;   // {busy, rstb, ck, load, fin}
    } sched_t;

    sched_t sched[16];

    task automatic chk(input string nm, input longint act,
                       input longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    function automatic logic [5:0] outs6();
        return {Out_Sr_Ck, Out_Sr_In, Out_Sr_Rstb,
                Out_Load_SC, Out_Finish_Sc, Out_Busy};
    endfunction

    function automatic logic [4:0] outs5();
        return {Out_Busy, Out_Sr_Rstb, Out_Sr_Ck,
                Out_Load_SC, Out_Finish_Sc};
    endfunction

    // Reference: frame per chip from base + fields, chip1 first, MSB first
    task automatic add_frames(input logic [47:0] d,
                              input logic [255:0] m);
        logic [CHIP_BITS-1:0] f;
        for (int k = 0; k < 4; k++) begin
            f = BASE_FRAME;
            for (int b = 0; b < 10; b++)
                f[DAC_POS + b] = d[(3 - k) * 12 + b];
            for (int b = 0; b < 64; b++)
                f[MASK_POS + b] = m[(3 - k) * 64 + b];
            for (int b = CHIP_BITS - 1; b >= 0; b--)
                exp_q.push_back(f[b]);
        end
    endtask

    task automatic rnd(output logic [47:0] d, output logic [255:0] m);
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        d = t[47:0];
        for (int i = 0; i < 8; i++) m[i * 32 +: 32] = $urandom();
    endtask

    // Called at a negedge; returns at the negedge of relative cycle 1
    task automatic kick(output int t);
        In_Set_SC = 1'b1;
        @(negedge Clk_10MHz);
        In_Set_SC = 1'b0;
        t = cyc;
    endtask

    task automatic wait_rel(input int c);
        while (cyc - t0 + 1 < c) @(negedge Clk_10MHz);
    endtask

    task automatic wait_fin(input string nm, input int target);
        int n;
        n = 0;
        while (fin_cnt < target && n < 12000) begin
            @(negedge Clk_10MHz);
            n++;
        end
        chk({nm, "_timeout"}, longint'(fin_cnt >= target), 1);
        repeat (4) @(negedge Clk_10MHz);
    endtask

    task automatic check_stream(input string nm, input int base);
        int wrong;
        int first;
        wrong = 0;
        first = -1;
        chk({nm, "_len"}, cap.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i >= cap.size() || cap[base + i] !== exp_q[i]) begin
                wrong++;
                if (first < 0) first = i;
            end
        end
        if (wrong != 0)
            $display("  %s first bad bit index %0d", nm, first);
        chk({nm, "_bits_wrong"}, wrong, 0);
    endtask

    initial begin
        int base, f0, dummy;
        logic [47:0]  da, db, dc;
        logic [255:0] ma, mb, mc;
        logic [9:0]   dexp [4];
        logic [9:0]   gd;
        logic [63:0]  gm;

        sched[0]  = '{1,    5'b11000};
        sched[1]  = '{2,    5'b10000};
        sched[2]  = '{5,    5'b10000};
        sched[3]  = '{6,    5'b11000};
        sched[4]  = '{7,    5'b11100};
        sched[5]  = '{8,    5'b11000};
        sched[6]  = '{4932, 5'b11000};
        sched[7]  = '{4933, 5'b11100};
        sched[8]  = '{4934, 5'b11010};
        sched[9]  = '{4935, 5'b11010};
        sched[10] = '{4936, 5'b11001};
        sched[11] = '{4937, 5'b11001};
        sched[12] = '{4938, 5'b01000};
        sched[13] = '{4939, 5'b01000};
        sched[14] = '{4940, 5'b01000};
        sched[15] = '{4945, 5'b01000};

        dexp = '{10'h3FF, 10'h000, 10'h155, 10'h2AA};

        // reset, then 100 idle cycles
        repeat (3) @(negedge Clk_10MHz);
        chk("in_reset", outs6(), 6'b001000);
        Rst_N = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk_10MHz);
            chk($sformatf("idle_%0d", i), outs6(), 6'b001000);
        end

        // directed load against the schedule table
        In_DAC_Code  = {12'h3FF, 12'h000, 12'h155, 12'h2AA};
        In_Mask_Code = {{64{1'b1}}, 192'd0};
        exp_q.delete();
        add_frames(In_DAC_Code, In_Mask_Code);
        base = cap.size();
        f0 = fin_cnt;
        kick(t0);
        for (int i = 0; i < 16; i++) begin
            wait_rel(sched[i].c);
            chk($sformatf("sched_c%0d", sched[i].c), outs5(), sched[i].v);
        end
        repeat (2) @(negedge Clk_10MHz);
        check_stream("directed", base);
        chk("directed_fin", fin_cnt - f0, 1);
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 10; b++)
                gd[b] = cap[base + k * CHIP_BITS +
                            (CHIP_BITS - 1 - DAC_POS - b)];
            for (int b = 0; b < 64; b++)
                gm[b] = cap[base + k * CHIP_BITS +
                            (CHIP_BITS - 1 - MASK_POS - b)];
            chk($sformatf("dac_chip%0d", k + 1), gd, dexp[k]);
            chk($sformatf("mask_chip%0d", k + 1), gm,
                (k == 0) ? {64{1'b1}} : 64'd0);
        end

        // level held high: exactly one load
        rnd(da, ma);
        In_DAC_Code = da;
        In_Mask_Code = ma;
        exp_q.delete();
        add_frames(da, ma);
        base = cap.size();
        f0 = fin_cnt;
        In_Set_SC = 1'b1;
        repeat (20000) @(negedge Clk_10MHz);
        In_Set_SC = 1'b0;
        repeat (4) @(negedge Clk_10MHz);
        check_stream("held", base);
        chk("held_fin", fin_cnt - f0, 1);
        chk("held_busy", Out_Busy, 0);

        // edge at 1000 ignored, edge at 4940 starts a new load
        rnd(da, ma);
        rnd(db, mb);
        In_DAC_Code = da;
        In_Mask_Code = ma;
        exp_q.delete();
        add_frames(da, ma);
        add_frames(db, mb);
        base = cap.size();
        f0 = fin_cnt;
        kick(t0);
        wait_rel(1000);
        kick(dummy);
        wait_rel(4938);
        chk("idle_at_4938", outs6(), 6'b001000);
        wait_rel(4940);
        In_DAC_Code = db;
        In_Mask_Code = mb;
        kick(t0);
        chk("restart_4940_busy", Out_Busy, 1);
        wait_fin("retrig", f0 + 2);
        check_stream("retrig", base);
        chk("retrig_fin", fin_cnt - f0, 2);

        // upstream change after LATCH has no effect
        rnd(da, ma);
        In_DAC_Code = da;
        In_Mask_Code = ma;
        exp_q.delete();
        add_frames(da, ma);
        base = cap.size();
        f0 = fin_cnt;
        kick(t0);
        wait_rel(3);
        rnd(db, mb);
        In_DAC_Code = db;
        In_Mask_Code = mb;
        wait_fin("shadow", f0 + 1);
        check_stream("shadow", base);

        // reset in the middle of the shift
        rnd(da, ma);
        In_DAC_Code = da;
        In_Mask_Code = ma;
        f0 = fin_cnt;
        kick(t0);
        wait_rel(2000);
        chk("pre_abort_busy", Out_Busy, 1);
        Rst_N = 1'b0;
        #1;
        chk("abort_outputs", outs6(), 6'b001000);
        repeat (3) @(negedge Clk_10MHz);
        Rst_N = 1'b1;
        repeat (2) @(negedge Clk_10MHz);
        chk("abort_no_fin", fin_cnt - f0, 0);
        rnd(db, mb);
        In_DAC_Code = db;
        In_Mask_Code = mb;
        exp_q.delete();
        add_frames(db, mb);
        base = cap.size();
        kick(t0);
        wait_fin("after_abort", f0 + 1);
        check_stream("after_abort", base);

        // edge at 4937 lost, edge at 4938 accepted
        rnd(da, ma);
        rnd(db, mb);
        rnd(dc, mc);
        In_DAC_Code = da;
        In_Mask_Code = ma;
        exp_q.delete();
        add_frames(da, ma);
        base = cap.size();
        f0 = fin_cnt;
        kick(t0);
        wait_rel(4937);
        kick(dummy);
        wait_rel(4942);
        chk("lost_4937", outs6(), 6'b001000);
        In_DAC_Code = db;
        In_Mask_Code = mb;
        add_frames(db, mb);
        kick(t0);
        wait_rel(4938);
        In_DAC_Code = dc;
        In_Mask_Code = mc;
        add_frames(dc, mc);
        kick(t0);
        chk("start_4938_busy", Out_Busy, 1);
        wait_fin("edge_bound", f0 + 3);
        check_stream("edge_bound", base);
        chk("edge_bound_fin", fin_cnt - f0, 3);

        chk("sdi_setup", m_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
